// File: rtl/bbox_pkg.sv
// Shared constants and types for the bounding-box message reader.
//   ADDR_*            slave register map (STATUS, READ_MSG)
//   STATUS_FLUSH_BIT  STATUS write bit that empties the slave FIFO
//   MSG_ID            expected header word ("RBB")
//   COORD_W           coordinate width
//   state_e           reader FSM states
package bbox_pkg;

  localparam int unsigned COORD_W          = 11;
  localparam logic [2:0]  ADDR_STATUS      = 3'd0;
  localparam logic [2:0]  ADDR_READ_MSG    = 3'd1;
  localparam int unsigned STATUS_FLUSH_BIT = 4;
  localparam logic [31:0] MSG_ID           = 32'h0052_4242;
  localparam logic [31:0] FLUSH_CMD        = 32'(1) << STATUS_FLUSH_BIT;

  typedef enum logic [3:0] {
    StIdle,
    StRdStat,
    StCapStat,
    StRdW,
    StCapW,
    StGap,
    StCheck,
    StFlush
  } state_e;

endpackage

// File: rtl/mm_pulse_master.sv
// Single-cycle Avalon-MM access generator.
//   clk, reset                  clock, asynchronous active-high reset
//   i_rd_req / i_wr_req         access request (read wins if both)
//   i_addr / i_wdata            address and write data for the request
//   o_chipselect/o_read/o_write bus strobes, one cycle wide
//   o_address / o_writedata     bus address/data, zero outside a pulse
//   o_cap                       high the cycle after a read pulse (readdata valid)
module mm_pulse_master (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_rd_req,
  input  logic        i_wr_req,
  input  logic [2:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_chipselect,
  output logic        o_read,
  output logic        o_write,
  output logic [2:0]  o_address,
  output logic [31:0] o_writedata,
  output logic        o_cap
);

  logic r_busy;
  logic r_cap;
  logic w_read;
  logic w_write;

  // A request is honoured only after an idle cycle, so the gap cycle is guaranteed here.
  // Reset gates the strobes combinationally so an in-flight access dies with it.
  assign w_read  = i_rd_req & ~r_busy & ~reset;
  assign w_write = i_wr_req & ~i_rd_req & ~r_busy & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_cap  <= 1'b0;
    end else begin
      r_busy <= w_read | w_write;
      r_cap  <= w_read;
    end
  end

  assign o_chipselect = w_read | w_write;
  assign o_read       = w_read;
  assign o_write      = w_write;
  assign o_address    = (w_read | w_write) ? i_addr : 3'd0;
  assign o_writedata  = w_write ? i_wdata : 32'd0;
  assign o_cap        = r_cap;

endmodule

// File: rtl/bbox_msg_reader.sv
// Polls the image block's MM slave and drains 3-word bounding-box messages.
//   clk, reset                       clock, asynchronous active-high reset
//   m_chipselect/m_read/m_write      Avalon-MM master strobes (single-cycle pulses)
//   m_address/m_writedata/m_readdata Avalon-MM address and data
//   bb_valid                         pulse: a new box was accepted
//   target_present                   last box had left<=right and top<=bottom
//   bb_left/right/top/bottom         edges of last accepted box
//   centre_x, width                  derived from the last accepted box
//   err_count                        malformed messages, saturating
module bbox_msg_reader #(
  parameter int unsigned POLL_INTERVAL = 1024,
  parameter int unsigned IMAGE_W       = 640,
  parameter int unsigned IMAGE_H       = 480,
  parameter logic [31:0] MSG_ID        = bbox_pkg::MSG_ID
) (
  input  logic        clk,
  input  logic        reset,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [2:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  output logic        bb_valid,
  output logic        target_present,
  output logic [10:0] bb_left,
  output logic [10:0] bb_right,
  output logic [10:0] bb_top,
  output logic [10:0] bb_bottom,
  output logic [10:0] centre_x,
  output logic [10:0] width,
  output logic [7:0]  err_count
);

  import bbox_pkg::*;

  localparam int unsigned          TimerW      = $clog2(POLL_INTERVAL) + 1;
  localparam logic [TimerW-1:0]    TimerReload = TimerW'(POLL_INTERVAL - 1);
  localparam logic [COORD_W-1:0]   XLim        = COORD_W'(IMAGE_W);
  localparam logic [COORD_W-1:0]   YLim        = COORD_W'(IMAGE_H);

  state_e              r_state;
  logic [TimerW-1:0]   r_timer;
  logic [1:0]          r_word;
  logic                r_rd_req;
  logic                r_wr_req;
  logic [2:0]          r_addr;
  logic [COORD_W-1:0]  r_x0, r_y0, r_x1, r_y1;
  logic                r_bb_valid;
  logic                r_present;
  logic [COORD_W-1:0]  r_left, r_right, r_top, r_bottom, r_centre, r_width;
  logic [7:0]          r_err;

  logic                w_cap;
  logic [7:0]          w_used;
  logic [COORD_W-1:0]  w_x, w_y;
  logic                w_bad;
  logic                w_present;
  logic [COORD_W:0]    w_sum;
  logic [COORD_W-1:0]  w_width;

  mm_pulse_master u_bus (
    .clk          (clk),
    .reset        (reset),
    .i_rd_req     (r_rd_req),
    .i_wr_req     (r_wr_req),
    .i_addr       (r_addr),
    .i_wdata      (FLUSH_CMD),
    .o_chipselect (m_chipselect),
    .o_read       (m_read),
    .o_write      (m_write),
    .o_address    (m_address),
    .o_writedata  (m_writedata),
    .o_cap        (w_cap)
  );

  assign w_used    = m_readdata[15:8];
  assign w_x       = m_readdata[26:16];
  assign w_y       = m_readdata[10:0];
  assign w_bad     = (r_x0 >= XLim) | (r_x1 >= XLim) | (r_y0 >= YLim) | (r_y1 >= YLim);
  assign w_present = (r_x0 <= r_x1) && (r_y0 <= r_y1);
  assign w_sum     = {1'b0, r_x0} + {1'b0, r_x1};
  assign w_width   = r_x1 - r_x0 + 11'd1;

  // Requests are set on the transition into a RD/FLUSH state so the bus pulse lands in it.
  // The poll timer is reloaded when each status read is issued, making the idle poll
  // period pulse-to-pulse; it free-runs down to zero and IDLE waits for zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_timer    <= '0;
      r_word     <= 2'd0;
      r_rd_req   <= 1'b0;
      r_wr_req   <= 1'b0;
      r_addr     <= ADDR_STATUS;
      r_x0       <= '0;
      r_y0       <= '0;
      r_x1       <= '0;
      r_y1       <= '0;
      r_bb_valid <= 1'b0;
      r_present  <= 1'b0;
      r_left     <= '0;
      r_right    <= '0;
      r_top      <= '0;
      r_bottom   <= '0;
      r_centre   <= '0;
      r_width    <= '0;
      r_err      <= '0;
    end else begin
      r_rd_req   <= 1'b0;
      r_wr_req   <= 1'b0;
      r_bb_valid <= 1'b0;
      if (r_timer != '0) r_timer <= r_timer - TimerW'(1);
      case (r_state)
        StIdle: begin
          if (r_timer == '0) begin
            r_state  <= StRdStat;
            r_rd_req <= 1'b1;
            r_addr   <= ADDR_STATUS;
            r_timer  <= TimerReload;
          end
        end
        StRdStat: r_state <= StCapStat;
        StCapStat: begin
          if (w_cap) begin
            if (w_used >= 8'd3) begin
              r_state  <= StRdW;
              r_word   <= 2'd0;
              r_rd_req <= 1'b1;
              r_addr   <= ADDR_READ_MSG;
            end else begin
              r_state  <= StIdle;
            end
          end
        end
        StRdW: r_state <= StCapW;
        StCapW: begin
          if (w_cap) begin
            r_state <= StGap;
            if (r_word == 2'd0) begin
              if (m_readdata != MSG_ID) begin
                r_state  <= StFlush;
                r_wr_req <= 1'b1;
                r_addr   <= ADDR_STATUS;
              end
            end else if (r_word == 2'd1) begin
              r_x0 <= w_x;
              r_y0 <= w_y;
            end else begin
              r_x1 <= w_x;
              r_y1 <= w_y;
            end
          end
        end
        StGap: begin
          if (r_word == 2'd2) begin
            r_state <= StCheck;
          end else begin
            r_state  <= StRdW;
            r_word   <= r_word + 2'd1;
            r_rd_req <= 1'b1;
            r_addr   <= ADDR_READ_MSG;
          end
        end
        StCheck: begin
          if (w_bad) begin
            r_state  <= StFlush;
            r_wr_req <= 1'b1;
            r_addr   <= ADDR_STATUS;
          end else begin
            r_left     <= r_x0;
            r_top      <= r_y0;
            r_right    <= r_x1;
            r_bottom   <= r_y1;
            r_centre   <= w_sum[COORD_W:1];
            r_width    <= w_present ? w_width : '0;
            r_present  <= w_present;
            r_bb_valid <= 1'b1;
            // Re-poll at once to drain any backlog.
            r_state    <= StRdStat;
            r_rd_req   <= 1'b1;
            r_addr     <= ADDR_STATUS;
            r_timer    <= TimerReload;
          end
        end
        StFlush: begin
          if (r_err != 8'hFF) r_err <= r_err + 8'd1;
          r_timer <= TimerReload;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bb_valid       = r_bb_valid;
  assign target_present = r_present;
  assign bb_left        = r_left;
  assign bb_right       = r_right;
  assign bb_top         = r_top;
  assign bb_bottom      = r_bottom;
  assign centre_x       = r_centre;
  assign width          = r_width;
  assign err_count      = r_err;

endmodule

// File: tb/tb_bbox_msg_reader.sv
module tb_bbox_msg_reader;

  localparam int POLL  = 32;
  localparam int IW    = 640;
  localparam int IH    = 480;
  localparam int BOUND = 4 * POLL + 40;
  localparam logic [31:0] RBB = 32'h0052_4242;
  localparam logic [31:0] BAD = 32'h0041_4141;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m_chipselect, m_read, m_write;
  logic [2:0]  m_address;
  logic [31:0] m_writedata;
  logic [31:0] s_rdata = 32'd0;
  logic        bb_valid, target_present;
  logic [10:0] bb_left, bb_right, bb_top, bb_bottom, centre_x, width;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  bbox_msg_reader #(
    .POLL_INTERVAL (POLL),
    .IMAGE_W       (IW),
    .IMAGE_H       (IH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .m_chipselect   (m_chipselect),
    .m_read         (m_read),
    .m_write        (m_write),
    .m_address      (m_address),
    .m_writedata    (m_writedata),
    .m_readdata     (s_rdata),
    .bb_valid       (bb_valid),
    .target_present (target_present),
    .bb_left        (bb_left),
    .bb_right       (bb_right),
    .bb_top         (bb_top),
    .bb_bottom      (bb_bottom),
    .centre_x       (centre_x),
    .width          (width),
    .err_count      (err_count)
  );

  // ---------------- slave model and bus logs ----------------
  typedef struct { int cyc; int addr; } rd_ev_t;
  logic [31:0] fifo[$];
  rd_ev_t      rd_log[$];
  int          bbv_log[$];
  logic [31:0] wr_data_log[$];
  int          wr_addr_log[$];
  int          cyc = 0;
  int          viol = 0;
  logic        prev_rd = 1'b0;
  logic        s_rd = 1'b0, s_wr = 1'b0;
  logic [2:0]  s_addr = 3'd0;
  logic [31:0] s_wdata = 32'd0;

  always @(negedge clk) begin
    s_rd    = m_chipselect & m_read;
    s_wr    = m_chipselect & m_write;
    s_addr  = m_address;
    s_wdata = m_writedata;
    if (s_rd) rd_log.push_back('{cyc, int'(m_address)});
    if (s_wr) begin
      wr_data_log.push_back(m_writedata);
      wr_addr_log.push_back(int'(m_address));
    end
    if (bb_valid) bbv_log.push_back(cyc);
    if (m_read && prev_rd) viol++;
    if (m_read && m_write) viol++;
    prev_rd = m_read;
  end

  always @(posedge clk) begin
    int n;
    cyc++;
    n = fifo.size();
    if (s_rd) begin
      if (s_addr == 3'd0) s_rdata <= {16'd0, 8'((n > 255) ? 255 : n), 8'd0};
      else if (s_addr == 3'd1 && n > 0) s_rdata <= fifo.pop_front();
      else s_rdata <= 32'd0;
    end
    if (s_wr && s_addr == 3'd0 && s_wdata[4]) fifo.delete();
  end

  // ---------------- reference model ----------------
  int m_l = 0, m_r = 0, m_t = 0, m_b = 0, m_c = 0, m_w = 0, m_err = 0;
  bit m_p = 0, m_ok = 0;

  task automatic model_reset();
    m_l = 0; m_r = 0; m_t = 0; m_b = 0; m_c = 0; m_w = 0; m_err = 0; m_p = 0;
  endtask

  task automatic model_apply(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2);
    int x0, y0, x1, y1;
    x0 = int'(w1 >> 16) % 2048;
    y0 = int'(w1) % 2048;
    x1 = int'(w2 >> 16) % 2048;
    y1 = int'(w2) % 2048;
    m_ok = (w0 == RBB) && x0 < IW && x1 < IW && y0 < IH && y1 < IH;
    if (m_ok) begin
      m_l = x0; m_r = x1; m_t = y0; m_b = y1;
      m_p = (x0 <= x1) && (y0 <= y1);
      m_c = (x0 + x1) / 2;
      m_w = m_p ? (x1 - x0 + 1) : 0;
    end else if (m_err < 255) begin
      m_err++;
    end
  endtask

  // ---------------- helpers ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int l, input int r, input int t, input int b,
                          input int c, input int w, input bit p, input int e);
    chk({tag, ".left"}, 32'(bb_left), l);
    chk({tag, ".right"}, 32'(bb_right), r);
    chk({tag, ".top"}, 32'(bb_top), t);
    chk({tag, ".bottom"}, 32'(bb_bottom), b);
    chk({tag, ".centre"}, 32'(centre_x), c);
    chk({tag, ".width"}, 32'(width), w);
    chk({tag, ".present"}, 32'(target_present), 32'(p));
    chk({tag, ".err"}, 32'(err_count), e);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".bb_valid"}, 32'(bb_valid), 0);
    chk_outs(tag, 0, 0, 0, 0, 0, 0, 1'b0, 0);
    chk({tag, ".m_read"}, 32'(m_read), 0);
    chk({tag, ".m_write"}, 32'(m_write), 0);
    chk({tag, ".m_cs"}, 32'(m_chipselect), 0);
    chk({tag, ".m_addr"}, 32'(m_address), 0);
    chk({tag, ".m_wdata"}, m_writedata, 0);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_log.delete();
    bbv_log.delete();
    wr_data_log.delete();
    wr_addr_log.delete();
  endtask

  task automatic send(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    fifo.push_back(w0);
    fifo.push_back(w1);
    fifo.push_back(w2);
    model_apply(w0, w1, w2);
  endtask

  task automatic wait_any(input int n);
    for (int i = 0; i < BOUND; i++) begin
      if (bbv_log.size() + wr_data_log.size() >= n) break;
      tick();
    end
  endtask

  function automatic logic [31:0] pack(input int x, input int y);
    return {5'd0, 11'(x), 5'd0, 11'(y)};
  endfunction

  function automatic int last_stat_before(input int c);
    int r = -1000;
    foreach (rd_log[i]) if (rd_log[i].addr == 0 && rd_log[i].cyc < c) r = rd_log[i].cyc;
    return r;
  endfunction

  function automatic int msg_reads();
    int k = 0;
    foreach (rd_log[i]) if (rd_log[i].addr == 1) k++;
    return k;
  endfunction

  // Checks the outcome of one message against the expected accept/reject decision.
  task automatic chk_txn(input string tag, input bit ok);
    chk({tag, ".valid"}, bbv_log.size(), ok ? 1 : 0);
    chk({tag, ".flush"}, wr_data_log.size(), ok ? 0 : 1);
    if (wr_data_log.size() > 0) begin
      chk({tag, ".wdata"}, wr_data_log[0], 32'h10);
      chk({tag, ".waddr"}, wr_addr_log[0], 0);
    end
    if (bbv_log.size() > 0) chk({tag, ".lat"}, bbv_log[0] - last_stat_before(bbv_log[0]), 12);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] w0;
    int x0, y0, x1, y1;
    bit ok;
    int l, r, t, b, c, w;
    bit p;
    int e;
  } vec_t;

  vec_t tbl[8];

  initial begin
    string tag;
    int st[$];
    int bound_hit;

    tbl[0] = '{RBB, 100, 50, 300, 200, 1'b1, 100, 300, 50, 200, 200, 201, 1'b1, 0};
    tbl[1] = '{RBB, 639, 479, 0, 0, 1'b1, 639, 0, 479, 0, 319, 0, 1'b0, 0};
    tbl[2] = '{BAD, 1, 1, 2, 2, 1'b0, 639, 0, 479, 0, 319, 0, 1'b0, 1};
    tbl[3] = '{RBB, 700, 10, 20, 30, 1'b0, 639, 0, 479, 0, 319, 0, 1'b0, 2};
    tbl[4] = '{RBB, 5, 5, 5, 5, 1'b1, 5, 5, 5, 5, 5, 1, 1'b1, 2};
    tbl[5] = '{RBB, 10, 480, 20, 30, 1'b0, 5, 5, 5, 5, 5, 1, 1'b1, 3};
    tbl[6] = '{RBB, 0, 0, 639, 479, 1'b1, 0, 639, 0, 479, 319, 640, 1'b1, 3};
    tbl[7] = '{RBB, 640, 0, 1, 1, 1'b0, 0, 639, 0, 479, 319, 640, 1'b1, 4};

    // Reset state
    repeat (3) tick();
    chk_reset("rst");
    reset = 1'b0;

    // used=2: no message reads, polls spaced by the poll interval
    clear_logs();
    fifo.push_back(RBB);
    fifo.push_back(pack(1, 1));
    repeat (3 * POLL + 10) tick();
    foreach (rd_log[i]) if (rd_log[i].addr == 0) st.push_back(rd_log[i].cyc);
    chk("t4.msg_reads", msg_reads(), 0);
    chk("t4.polls", (st.size() >= 3) ? 1 : 0, 1);
    if (st.size() >= 3) begin
      chk("t4.ival1", st[1] - st[0], POLL);
      chk("t4.ival2", st[2] - st[1], POLL);
    end
    fifo.delete();

    // Table of single messages
    for (int i = 0; i < 8; i++) begin
      clear_logs();
      send(tbl[i].w0, pack(tbl[i].x0, tbl[i].y0), pack(tbl[i].x1, tbl[i].y1));
      wait_any(1);
      repeat (4) tick();
      tag = $sformatf("vec%0d", i);
      chk_txn(tag, tbl[i].ok);
      chk_outs(tag, tbl[i].l, tbl[i].r, tbl[i].t, tbl[i].b, tbl[i].c, tbl[i].w, tbl[i].p,
               tbl[i].e);
    end

    // Two queued messages: back-to-back, no timer wait
    clear_logs();
    send(RBB, pack(100, 50), pack(300, 200));
    send(RBB, pack(20, 30), pack(60, 90));
    wait_any(2);
    repeat (4) tick();
    chk("t5.valids", bbv_log.size(), 2);
    if (bbv_log.size() == 2) chk("t5.gap", bbv_log[1] - bbv_log[0], 12);
    chk_outs("t5", 20, 60, 30, 90, 40, 41, 1'b1, m_err);

    // Randomised messages against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] w0;
      int x0, y0, x1, y1, tmp;
      w0 = ($urandom_range(0, 9) == 0) ? $urandom : RBB;
      x0 = $urandom_range(0, 700);
      x1 = $urandom_range(0, 700);
      y0 = $urandom_range(0, 520);
      y1 = $urandom_range(0, 520);
      if ($urandom_range(0, 1) == 1) begin
        if (x0 > x1) begin tmp = x0; x0 = x1; x1 = tmp; end
        if (y0 > y1) begin tmp = y0; y0 = y1; y1 = tmp; end
      end
      clear_logs();
      send(w0, pack(x0, y0), pack(x1, y1));
      wait_any(1);
      repeat (4) tick();
      tag = $sformatf("rnd%0d", i);
      chk_txn(tag, m_ok);
      chk_outs(tag, m_l, m_r, m_t, m_b, m_c, m_w, m_p, m_err);
    end

    // Reset during CAP_W(1), then resync via header flush
    clear_logs();
    fifo.push_back(RBB);
    fifo.push_back(pack(100, 50));
    fifo.push_back(pack(300, 200));
    bound_hit = 1;
    for (int i = 0; i < BOUND; i++) begin
      if (msg_reads() >= 2) begin bound_hit = 0; break; end
      tick();
    end
    chk("t6.reached_w1", bound_hit, 0);
    tick();
    reset = 1'b1;
    #1;
    chk_reset("t6.rst");
    repeat (2) tick();
    reset = 1'b0;
    model_reset();
    clear_logs();
    // Leftover word 2 is now taken as a header, so the whole backlog is flushed.
    fifo.push_back(RBB);
    fifo.push_back(pack(100, 50));
    fifo.push_back(pack(300, 200));
    model_apply(pack(300, 200), RBB, pack(100, 50));
    wait_any(1);
    repeat (4) tick();
    chk_txn("t6.resync", 1'b0);
    chk("t6.resync.err", 32'(err_count), m_err);
    clear_logs();
    send(RBB, pack(100, 50), pack(300, 200));
    wait_any(1);
    repeat (4) tick();
    chk_txn("t6.msg", 1'b1);
    chk_outs("t6.msg", 100, 300, 50, 200, 200, 201, 1'b1, 1);

    // Error counter saturation
    for (int k = 0; k < 300; k++) begin
      clear_logs();
      send(BAD, pack(1, 1), pack(2, 2));
      wait_any(1);
      repeat (2) tick();
    end
    repeat (4) tick();
    chk("sat.err", 32'(err_count), 255);
    chk("sat.model", 32'(err_count), m_err);
    chk("sat.flush", wr_data_log.size(), 1);

    chk("bus_rule", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
